// File: rtl/ulpi_uart_framer_if.sv
// Handshake bundle between the ULPI capture stage, the framer and the UART.
// The master side captures ULPI bytes and models the UART busy line.
// The slave side is the framer itself.
interface ulpi_uart_framer_if #(
  parameter int FIFO_AW = 4
);
  logic [7:0]       in_data;
  logic             in_cmd;
  logic             in_valid;
  logic             uart_busy;
  logic [7:0]       uart_data;
  logic             uart_send;
  logic [FIFO_AW:0] fifo_level;
  logic             fifo_full;
  logic [7:0]       dropped;

  modport master (
    output in_data,
    output in_cmd,
    output in_valid,
    output uart_busy,
    input  uart_data,
    input  uart_send,
    input  fifo_level,
    input  fifo_full,
    input  dropped
  );

  modport slave (
    input  in_data,
    input  in_cmd,
    input  in_valid,
    input  uart_busy,
    output uart_data,
    output uart_send,
    output fifo_level,
    output fifo_full,
    output dropped
  );
endinterface

// File: rtl/ulpi_uart_framer.sv
// Byte FIFO plus framing FSM between the ULPI capture stage and the UART.
// Every buffered byte leaves as a 4-byte frame SYNC, TAG, DATA, CHK, one
// UART byte at a time, paced by the UART busy (TiP) line. Bytes arriving
// while the FIFO is full are dropped and counted (saturating).
module ulpi_uart_framer #(
  parameter int         FIFO_AW   = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  ulpi_uart_framer_if.slave bus
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_L  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [7:0]         TAG_CMD  = 8'h01;
  localparam logic [7:0]         TAG_DATA = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_t;

  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [7:0]         drop_cnt;

  logic               push_ok;
  logic               push_rej;
  logic               pop;
  logic [8:0]         head;
  logic [7:0]         head_tag;

  state_t             state;
  state_t             state_n;
  logic [1:0]         idx;
  logic [1:0]         idx_n;
  logic [7:0]         tag_q;
  logic [7:0]         data_q;
  logic [7:0]         chk_q;
  logic [7:0]         uart_data_q;
  logic               send_q;
  logic               load_byte;
  logic [7:0]         byte_n;

  // Full is judged on the level at the start of the cycle, so a same-cycle pop never makes room.
  assign push_ok  = bus.in_valid && (level != DEPTH_L);
  assign push_rej = bus.in_valid && (level == DEPTH_L);
  assign head     = mem[rd_ptr];
  assign head_tag = head[8] ? TAG_CMD : TAG_DATA;

  // FIFO storage; the array carries no reset since only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {bus.in_cmd, bus.in_data};
    end
  end

  // Pointers wrap modulo depth; the level is its own counter so full and empty are unambiguous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Rejected bytes are counted, holding at 255 instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (push_rej && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Next-state logic: pop when idle, strobe once per byte, then wait for a full busy pulse.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pop       = 1'b0;
    load_byte = 1'b0;
    byte_n    = uart_data_q;
    case (state)
      IDLE: begin
        if ((level != '0) && !bus.uart_busy) begin
          pop       = 1'b1;
          idx_n     = 2'd0;
          load_byte = 1'b1;
          byte_n    = SYNC_BYTE;
          state_n   = SEND;
        end
      end
      SEND: begin
        state_n = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.uart_busy) begin
          state_n = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!bus.uart_busy) begin
          if (idx == 2'd3) begin
            state_n = IDLE;
          end else begin
            idx_n     = idx + 2'd1;
            load_byte = 1'b1;
            state_n   = SEND;
            case (idx)
              2'd0:    byte_n = tag_q;
              2'd1:    byte_n = data_q;
              default: byte_n = chk_q;
            endcase
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, byte index and the output strobe; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 2'd0;
      send_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      send_q <= (state_n == SEND);
    end
  end

  // The frame's TAG, DATA and CHK are captured from the head entry at the moment it is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q  <= '0;
      data_q <= '0;
      chk_q  <= '0;
    end else if (pop) begin
      tag_q  <= head_tag;
      data_q <= head[7:0];
      chk_q  <= head_tag ^ head[7:0];
    end
  end

  // The UART byte is loaded on entry to SEND and held steady while the UART shifts it out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_data_q <= '0;
    end else if (load_byte) begin
      uart_data_q <= byte_n;
    end
  end

  assign bus.uart_data  = uart_data_q;
  assign bus.uart_send  = send_q;
  assign bus.fifo_level = level;
  assign bus.fifo_full  = (level == DEPTH_L);
  assign bus.dropped    = drop_cnt;

endmodule

// File: tb/tb_ulpi_uart_framer.sv
// Directed bench for ulpi_uart_framer: a UART model that goes busy for a
// fixed number of cycles after each strobe, and a scoreboard of expected
// UART bytes filled when bytes are pushed and drained on every strobe.
module tb_ulpi_uart_framer;

  localparam int         FIFO_AW     = 4;
  localparam logic [7:0] SYNC        = 8'hA5;
  localparam int         BUSY_CYCLES = 10;

  logic clk = 1'b0;
  logic rst;

  ulpi_uart_framer_if #(.FIFO_AW(FIFO_AW)) bus ();

  ulpi_uart_framer #(
    .FIFO_AW   (FIFO_AW),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_checks   = 0;
  int         n_pass     = 0;
  int         n_fail     = 0;
  int         cyc        = 0;
  int         send_count = 0;
  int         send_cyc   = 0;
  int         busy_cnt   = 0;
  logic       hold_busy  = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Queue the four UART bytes one accepted ULPI byte must produce.
  task automatic pushFrame(input logic [7:0] data, input logic cmd);
    logic [7:0] tag;
    tag = cmd ? 8'h01 : 8'h02;
    exp_q.push_back(SYNC);
    exp_q.push_back(tag);
    exp_q.push_back(data);
    exp_q.push_back(tag ^ data);
  endtask

  // One-cycle in_valid strobe, driven between edges.
  task automatic applyStimulus(input logic [7:0] data, input logic cmd);
    bus.in_data  = data;
    bus.in_cmd   = cmd;
    bus.in_valid = 1'b1;
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitSendCount(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (send_count >= target) break;
      @(negedge clk);
      #1;
    end
    if (send_count < target) checkOutput(tag, 32'(send_count), 32'(target));
  endtask

  task automatic waitDrain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if ((exp_q.size() == 0) && !bus.uart_busy) break;
      @(negedge clk);
      #1;
    end
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // UART model plus scoreboard: every strobe is compared, then busy is held for BUSY_CYCLES.
  always @(negedge clk) begin
    if (bus.uart_send) begin
      send_count = send_count + 1;
      send_cyc   = cyc;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_send", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("uart_byte", 32'(bus.uart_data), 32'(mon_exp));
      end
      busy_cnt = BUSY_CYCLES;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    bus.uart_busy = (busy_cnt > 0) || hold_busy;
  end

  initial begin
    int base;
    int push_cyc;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_cmd   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_send",    32'(bus.uart_send),  32'd0);
    checkOutput("rst_data",    32'(bus.uart_data),  32'd0);
    checkOutput("rst_level",   32'(bus.fifo_level), 32'd0);
    checkOutput("rst_full",    32'(bus.fifo_full),  32'd0);
    checkOutput("rst_dropped", 32'(bus.dropped),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    $display("[TB] data byte frame");
    base     = send_count;
    push_cyc = cyc;
    pushFrame(8'h3C, 1'b0);
    applyStimulus(8'h3C, 1'b0);
    checkOutput("t1_level_visible", 32'(bus.fifo_level), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("t1_level_popped", 32'(bus.fifo_level), 32'd0);
    waitSendCount(base + 1, 20, "t1_first_send_timeout");
    checkOutput("t1_latency", 32'(send_cyc - push_cyc), 32'd2);
    waitDrain(200, "t1_drain");

    $display("[TB] cmd byte frame");
    pushFrame(8'h4D, 1'b1);
    applyStimulus(8'h4D, 1'b1);
    checkOutput("t2_level_visible", 32'(bus.fifo_level), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("t2_level_popped", 32'(bus.fifo_level), 32'd0);
    waitDrain(200, "t2_drain");

    $display("[TB] fill with busy held");
    base = send_count;
    for (int i = 0; i < 17; i++) begin
      pushFrame(8'(8'h40 + i), (i % 2) == 1);
      applyStimulus(8'(8'h40 + i), (i % 2) == 1);
      if (i == 2) hold_busy = 1'b1;
    end
    checkOutput("t3_level_full", 32'(bus.fifo_level), 32'd16);
    checkOutput("t3_full_flag",  32'(bus.fifo_full),  32'd1);
    checkOutput("t3_dropped0",   32'(bus.dropped),    32'd0);
    applyStimulus(8'hEE, 1'b0);
    checkOutput("t3_dropped1",   32'(bus.dropped),    32'd1);
    checkOutput("t3_level_held", 32'(bus.fifo_level), 32'd16);

    $display("[TB] push rejected during same-cycle pop");
    hold_busy = 1'b0;
    waitSendCount(base + 4, 200, "t4_frame_timeout");
    for (int i = 0; i < 40; i++) begin
      if (!bus.uart_busy) break;
      @(negedge clk);
      #1;
    end
    checkOutput("t4_busy_released", 32'(bus.uart_busy), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("t4_full_before", 32'(bus.fifo_full), 32'd1);
    applyStimulus(8'hEF, 1'b0);
    checkOutput("t4_level_15",  32'(bus.fifo_level), 32'd15);
    checkOutput("t4_dropped2",  32'(bus.dropped),    32'd2);
    checkOutput("t4_not_full",  32'(bus.fifo_full),  32'd0);

    $display("[TB] drop counter saturation");
    hold_busy = 1'b1;
    pushFrame(8'h77, 1'b1);
    applyStimulus(8'h77, 1'b1);
    checkOutput("t5_refull", 32'(bus.fifo_level), 32'd16);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'(i), 1'b0);
      if (i == 251) checkOutput("t5_dropped254", 32'(bus.dropped), 32'd254);
      if (i == 252) checkOutput("t5_dropped255", 32'(bus.dropped), 32'd255);
    end
    checkOutput("t5_saturated",  32'(bus.dropped),    32'd255);
    checkOutput("t5_level_held", 32'(bus.fifo_level), 32'd16);
    hold_busy = 1'b0;
    waitDrain(3000, "t5_drain");

    $display("[TB] reset mid-frame");
    base = send_count;
    pushFrame(8'h11, 1'b0);
    applyStimulus(8'h11, 1'b0);
    waitSendCount(base + 3, 100, "t6_data_timeout");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_data_before_rst", 32'(bus.uart_data), 32'h11);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_send",    32'(bus.uart_send),  32'd0);
    checkOutput("t6_rst_data",    32'(bus.uart_data),  32'd0);
    checkOutput("t6_rst_level",   32'(bus.fifo_level), 32'd0);
    checkOutput("t6_rst_full",    32'(bus.fifo_full),  32'd0);
    checkOutput("t6_rst_dropped", 32'(bus.dropped),    32'd0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    pushFrame(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    waitDrain(300, "t6_drain");

    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
